exception_ctrl: RTL and testbench
=================================

// Module: exception_ctrl
// PURPOSE
//  Consumer end of the MEM->ctrl interface (mem_ctrl_t). Commits exceptions, interrupts and ERTN.
//  Aggregates stage pause requests into ctrl_t, and drives the flush/redirect (ctrl_pc_t) to the PC stage.
//  Emits one-cycle CSR exception-update pulses (ERA/ESTAT.Ecode/BADV) to the CSR file.
//  Sits between the MEM stage, the CSR file and every pipeline register's pause/flush inputs.
// PARAMETERS
//  RECOVER_CYCLES  2        cycles after a flush during which new exceptions/interrupts are ignored (>=1)
//  ECODE_TLBR      7'h3F    cause code of TLB refill; redirects to tlbrentry instead of eentry
//  ECODE_ADEF      7'h08    fetch address error; BADV source = pc
//  WDOG_LIMIT      1024     consecutive-pause threshold (PAUSE_WATCHDOG_EN only)
// PORTS
//  clk            in   1    clock
//  rst            in   1    synchronous reset, active-low
//  mem_valid      in   1    mem_ctrl_i carries a real instruction this cycle
//  mem_ctrl_i     in   122  mem_ctrl_t: is_exception[5:0], exception_cause[5:0][6:0], pc, exception_addr, is_ertn, pause_mem, aluop
//  pause_i        in   4    pause_t: {pause_id, pause_dispatch, pause_ex, pause_mem}
//  int_pending    in   1    CSR: enabled interrupt pending and CRMD.IE=1
//  csr_eentry     in   32   exception entry
//  csr_tlbrentry  in   32   TLB-refill entry
//  csr_era        in   32   return address for ERTN
//  ctrl_o         out  8    ctrl_t: pause[6:0] {wb,mem,ex,dispatch,id,if,pc}, exception_flush
//  ctrl_pc_o      out  33   ctrl_pc_t: exception_new_pc, is_interrupt
//  exc_we         out  1    pulse: write ERA/Ecode (and BADV if exc_badv_we), push PLV/IE
//  exc_ecode      out  7    committed cause
//  exc_era        out  32   committed pc
//  exc_badv_we    out  1    BADV valid with exc_we
//  exc_badv       out  32   bad virtual address
//  ertn_o         out  1    pulse: restore PLV/IE
//  wdog_timeout   out  1    sticky watchdog flag (tied 0 without PAUSE_WATCHDOG_EN)
// BEHAVIOUR
//  Reset (rst=0 at edge): state=IDLE, all outputs 0, recover counter 0.
//  Pause (combinational, any state): request at stage k sets pause for stage k and all earlier ones.
//   pause_mem -> pause[5:0]=1; pause_ex -> [4:0]; pause_dispatch -> [3:0]; pause_id -> [2:0]. pause[6] always 0.
//   In FLUSH state pause forced to 0.
//  Commit in IDLE: taken when mem_valid & ~pause_mem & (|is_exception | is_ertn | int_pending).
//   Priority: int_pending > is_exception[5] (fetch) > [4] > ... > [0] (mem) > is_ertn.
//   Interrupt: ecode=7'h00, is_interrupt=1, new_pc=csr_eentry, exc_era=pc.
//   Exception bit i: ecode=exception_cause[i]; new_pc = tlbrentry if ecode==ECODE_TLBR, else eentry.
//    BADV: ADEF -> pc. ALE / TLB causes (01,02,03,04,07,09,3F) -> exception_addr. Other causes -> exc_badv_we=0.
//   ERTN alone: new_pc=csr_era, ertn_o=1, exc_we=0.
//  Latency: commit seen at edge N -> registered outputs valid for cycle N+1 only.
//   In N+1: exception_flush=1, exc_we/ertn_o=1, ctrl_pc_o valid, state=FLUSH.
//  FSM: IDLE -(commit)-> FLUSH -(1 cycle)-> RECOVER -(RECOVER_CYCLES cycles)-> IDLE.
//   In FLUSH/RECOVER, mem_ctrl_i and int_pending are ignored (wrong-path contents).
//   Flush and pulse outputs are 0 outside FLUSH; exception_new_pc holds its last value.
//  mem_valid=0 or pause_mem=1: no commit. Pending interrupt waits for the next valid unpaused instruction.
//  Reset mid-FLUSH/RECOVER: back to IDLE next cycle with all outputs 0.
// CONFIGURATION
//  PAUSE_WATCHDOG_EN defined:
//   - 16-bit counter increments each cycle |ctrl_o.pause is 1 and clears when it is 0.
//   - Reaching WDOG_LIMIT sets wdog_timeout; it stays set until reset. Counter saturates.
//  Undefined: no counter; wdog_timeout tied to 0.
// TESTING
//  1. pause_ex=1, rest 0 -> pause=7'b0011111, flush=0; release -> pause=0 same cycle.
//  2. mem_valid, pc=0x1C000100, is_exception[1]=1, cause=7'h09, addr=0x1C0000F3, eentry=0x1C008000
//     -> N+1: flush=1, new_pc=0x1C008000, ecode=09, era=0x1C000100, badv=0x1C0000F3, badv_we=1; N+2: flush=0.
//  3. is_exception[5] cause 3F + [1] cause 09 together -> ecode=3F, new_pc=tlbrentry, badv=exception_addr.
//  4. int_pending=1 with is_ertn=1 -> is_interrupt=1, ecode=00, ertn_o=0; then is_ertn alone after RECOVER
//     -> new_pc=csr_era=0x1C000200, ertn_o=1.
//  5. Second exception in the FLUSH cycle and the RECOVER_CYCLES cycles after -> ignored (no second flush);
//     same input one cycle later -> taken.
//  6. rst=0 during FLUSH -> next cycle flush=0, state IDLE; with PAUSE_WATCHDOG_EN, pause_mem held
//     WDOG_LIMIT cycles -> wdog_timeout=1 and stays set.

Source files
------------

// File: rtl/exception_ctrl_if.sv
// exception_ctrl_if: MEM/CSR <-> exception controller bundle
// master: the MEM stage / CSR file side, which drives the instruction, pause and CSR inputs.
// slave:  exception_ctrl, which drives pause/flush, redirect and CSR update outputs.
// mem_ctrl_i layout: {is_exception[5:0], exception_cause[5:0][6:0], pc, exception_addr, is_ertn, pause_mem, aluop[7:0]}
// ctrl_o layout: {pause[6:0] {wb,mem,ex,dispatch,id,if,pc}, exception_flush}; ctrl_pc_o: {exception_new_pc, is_interrupt}
interface exception_ctrl_if;
  logic         mem_valid;
  logic [121:0] mem_ctrl_i;
  logic [3:0]   pause_i;
  logic         int_pending;
  logic [31:0]  csr_eentry;
  logic [31:0]  csr_tlbrentry;
  logic [31:0]  csr_era;
  logic [7:0]   ctrl_o;
  logic [32:0]  ctrl_pc_o;
  logic         exc_we;
  logic [6:0]   exc_ecode;
  logic [31:0]  exc_era;
  logic         exc_badv_we;
  logic [31:0]  exc_badv;
  logic         ertn_o;
  logic         wdog_timeout;
  modport master (
    output mem_valid, mem_ctrl_i, pause_i, int_pending, csr_eentry, csr_tlbrentry, csr_era,
    input  ctrl_o, ctrl_pc_o, exc_we, exc_ecode, exc_era, exc_badv_we, exc_badv, ertn_o, wdog_timeout
  );
  modport slave (
    input  mem_valid, mem_ctrl_i, pause_i, int_pending, csr_eentry, csr_tlbrentry, csr_era,
    output ctrl_o, ctrl_pc_o, exc_we, exc_ecode, exc_era, exc_badv_we, exc_badv, ertn_o, wdog_timeout
  );
endinterface

// File: rtl/exception_ctrl.sv
// exception_ctrl: commits exceptions/interrupts/ERTN from MEM, aggregates pauses, drives flush/redirect and CSR update pulses
// Ports:
//   clk  clock
//   rst  synchronous reset, active-low
//   bus  exception_ctrl_if.slave
//        in : mem_valid, mem_ctrl_i[121:0], pause_i {id,dispatch,ex,mem}, int_pending, csr_eentry, csr_tlbrentry, csr_era
//        out: ctrl_o {pause[6:0], exception_flush}, ctrl_pc_o {exception_new_pc, is_interrupt},
//             exc_we, exc_ecode, exc_era, exc_badv_we, exc_badv, ertn_o, wdog_timeout
// Optional feature: define PAUSE_WATCHDOG_EN to build the sticky consecutive-pause watchdog;
// without it wdog_timeout is tied to 0.
module exception_ctrl #(
  parameter int         RECOVER_CYCLES = 2,
  parameter logic [6:0] ECODE_TLBR     = 7'h3F,
  parameter logic [6:0] ECODE_ADEF     = 7'h08,
  parameter int         WDOG_LIMIT     = 1024
) (
  input logic             clk,
  input logic             rst,
  exception_ctrl_if.slave bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FLUSH   = 2'd1;
  localparam logic [1:0] RECOVER = 2'd2;
  logic [1:0]  state;
  logic [15:0] rec_cnt;
  logic        flush_q;
  logic [31:0] new_pc_q;
  logic        is_int_q;
  logic [5:0]  is_exc;
  logic [31:0] pc;
  logic [31:0] exc_addr;
  logic        is_ertn;
  logic        pause_mem_f;
  logic [6:0]  sel_cause;
  logic        any_exc;
  logic        irq;
  logic        commit;
  logic        badv_pc;
  logic        badv_addr;
  logic [6:0]  pause;
  logic        unused_aluop;
  assign is_exc       = bus.mem_ctrl_i[121:116];
  assign pc           = bus.mem_ctrl_i[73:42];
  assign exc_addr     = bus.mem_ctrl_i[41:10];
  assign is_ertn      = bus.mem_ctrl_i[9];
  assign pause_mem_f  = bus.mem_ctrl_i[8];
  assign unused_aluop = ^bus.mem_ctrl_i[7:0];
  assign any_exc      = |is_exc;
  assign irq          = bus.int_pending;
  // Ascending scan so the highest (earliest-stage) exception bit wins.
  always_comb begin
    sel_cause = '0;
    for (int i = 0; i < 6; i++)
      if (is_exc[i]) sel_cause = bus.mem_ctrl_i[74 + 7 * i +: 7];
  end
  assign badv_pc   = sel_cause == ECODE_ADEF;
  assign badv_addr = sel_cause inside {7'h01, 7'h02, 7'h03, 7'h04, 7'h07, 7'h09, ECODE_TLBR};
  // Either copy of the MEM pause (bundle field or pause_t) holds the instruction back.
  assign commit = state == IDLE && bus.mem_valid && !bus.pause_i[0] && !pause_mem_f && (any_exc || is_ertn || irq);
  assign pause = state == FLUSH ? 7'h00 :
                 bus.pause_i[0] ? 7'h3F :
                 bus.pause_i[1] ? 7'h1F :
                 bus.pause_i[2] ? 7'h0F :
                 bus.pause_i[3] ? 7'h07 : 7'h00;
  assign bus.ctrl_o    = {pause, flush_q};
  assign bus.ctrl_pc_o = {new_pc_q, is_int_q};
  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      rec_cnt         <= '0;
      flush_q         <= 1'b0;
      new_pc_q        <= '0;
      is_int_q        <= 1'b0;
      bus.exc_we      <= 1'b0;
      bus.exc_ecode   <= '0;
      bus.exc_era     <= '0;
      bus.exc_badv_we <= 1'b0;
      bus.exc_badv    <= '0;
      bus.ertn_o      <= 1'b0;
    end else begin
      state   <= state == IDLE ? (commit ? FLUSH : IDLE) :
                 state == FLUSH ? RECOVER :
                 rec_cnt == 16'd0 ? IDLE : RECOVER;
      rec_cnt <= state == FLUSH ? 16'(RECOVER_CYCLES - 1) :
                 (state == RECOVER && rec_cnt != 16'd0) ? rec_cnt - 16'd1 : rec_cnt;
      flush_q         <= commit;
      bus.exc_we      <= commit && (irq || any_exc);
      bus.ertn_o      <= commit && !irq && !any_exc;
      bus.exc_badv_we <= commit && !irq && any_exc && (badv_pc || badv_addr);
      if (commit) begin
        new_pc_q <= irq ? bus.csr_eentry :
                    !any_exc ? bus.csr_era :
                    sel_cause == ECODE_TLBR ? bus.csr_tlbrentry : bus.csr_eentry;
        is_int_q <= irq;
        if (irq || any_exc) begin
          bus.exc_ecode <= irq ? 7'h00 : sel_cause;
          bus.exc_era   <= pc;
        end
        if (!irq && any_exc && (badv_pc || badv_addr)) bus.exc_badv <= badv_pc ? pc : exc_addr;
      end
    end
  end
`ifdef PAUSE_WATCHDOG_EN
  logic [15:0] wdog_cnt;
  always_ff @(posedge clk) begin
    if (!rst) begin
      wdog_cnt         <= '0;
      bus.wdog_timeout <= 1'b0;
    end else begin
      wdog_cnt <= ~|pause ? 16'd0 : &wdog_cnt ? wdog_cnt : wdog_cnt + 16'd1;
      if (|pause && 32'(wdog_cnt) + 32'd1 >= 32'(WDOG_LIMIT)) bus.wdog_timeout <= 1'b1;
    end
  end
`else
  logic unused_wdog;
  assign unused_wdog      = WDOG_LIMIT == 0;
  assign bus.wdog_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_exception_ctrl.sv
// tb_exception_ctrl: table-driven and directed checks of exception_ctrl
module tb_exception_ctrl;
  localparam logic [31:0] PC     = 32'h1C000100;
  localparam logic [31:0] ADDR   = 32'h1C0000F3;
  localparam logic [31:0] EENTRY = 32'h1C008000;
  localparam logic [31:0] TLBR   = 32'h1C00F000;
  localparam logic [31:0] ERA    = 32'h1C000200;
  localparam int          WDOG   = 1024;
  typedef struct {
    logic [3:0] p;
    logic [6:0] exp;
  } pvec_t;
  typedef struct {
    logic [5:0]  exc;
    logic [41:0] causes;
    logic        ip;
    logic        ertn;
    logic [6:0]  ecode;
    logic [31:0] npc;
    logic        isint;
    logic        we;
    logic        ertn_o;
    logic        bwe;
    logic [31:0] badv;
  } cvec_t;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  pvec_t pv[7];
  cvec_t cv[7];
  exception_ctrl_if bus ();
  exception_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [121:0] mk(input logic [5:0] exc, input logic [41:0] causes, input logic ertn, input logic pm);
    return {exc, causes, PC, ADDR, ertn, pm, 8'h00};
  endfunction
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [5:0] exc, input logic [41:0] causes, input logic ip, input logic ertn);
    bus.mem_valid   = v;
    bus.mem_ctrl_i  = mk(exc, causes, ertn, 1'b0);
    bus.int_pending = ip;
  endtask
  task automatic idle_in();
    drive(1'b0, 6'd0, 42'd0, 1'b0, 1'b0);
    bus.pause_i = 4'd0;
  endtask
  initial begin
    pv[0] = '{4'b0000, 7'h00};
    pv[1] = '{4'b0010, 7'h1F};
    pv[2] = '{4'b0000, 7'h00};
    pv[3] = '{4'b0001, 7'h3F};
    pv[4] = '{4'b0100, 7'h0F};
    pv[5] = '{4'b1000, 7'h07};
    pv[6] = '{4'b1010, 7'h1F};
    cv[0] = '{6'b000010, {28'd0, 7'h09, 7'd0}, 1'b0, 1'b0, 7'h09, EENTRY, 1'b0, 1'b1, 1'b0, 1'b1, ADDR};
    cv[1] = '{6'b100010, {7'h3F, 21'd0, 7'h09, 7'd0}, 1'b0, 1'b0, 7'h3F, TLBR, 1'b0, 1'b1, 1'b0, 1'b1, ADDR};
    cv[2] = '{6'b100000, {7'h08, 35'd0}, 1'b0, 1'b0, 7'h08, EENTRY, 1'b0, 1'b1, 1'b0, 1'b1, PC};
    cv[3] = '{6'b000001, {35'd0, 7'h0B}, 1'b0, 1'b0, 7'h0B, EENTRY, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};
    cv[4] = '{6'b000000, 42'd0, 1'b1, 1'b1, 7'h00, EENTRY, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0};
    cv[5] = '{6'b000000, 42'd0, 1'b0, 1'b1, 7'h00, ERA, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0};
    cv[6] = '{6'b001100, {14'd0, 7'h0B, 7'h09, 14'd0}, 1'b0, 1'b0, 7'h0B, EENTRY, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};
    bus.csr_eentry    = EENTRY;
    bus.csr_tlbrentry = TLBR;
    bus.csr_era       = ERA;
    idle_in();
    rst = 1'b0;
    cyc(2);
    chk("rst ctrl_o", 32'(bus.ctrl_o), 32'd0);
    chk("rst ctrl_pc_o", bus.ctrl_pc_o[32:1], 32'd0);
    chk("rst is_interrupt", 32'(bus.ctrl_pc_o[0]), 32'd0);
    chk("rst exc_we", 32'(bus.exc_we), 32'd0);
    chk("rst ertn_o", 32'(bus.ertn_o), 32'd0);
    chk("rst exc_badv_we", 32'(bus.exc_badv_we), 32'd0);
    chk("rst exc_ecode", 32'(bus.exc_ecode), 32'd0);
    chk("rst exc_era", bus.exc_era, 32'd0);
    chk("rst exc_badv", bus.exc_badv, 32'd0);
    chk("rst wdog", 32'(bus.wdog_timeout), 32'd0);
    rst = 1'b1;
    cyc(1);
    foreach (pv[i]) begin
      bus.pause_i = pv[i].p;
      #1;
      chk($sformatf("pause[%0d]", i), 32'(bus.ctrl_o), 32'({pv[i].exp, 1'b0}));
    end
    idle_in();
    cyc(2);
    foreach (cv[i]) begin
      drive(1'b1, cv[i].exc, cv[i].causes, cv[i].ip, cv[i].ertn);
      cyc(1);
      chk($sformatf("v%0d flush", i), 32'(bus.ctrl_o[0]), 32'd1);
      chk($sformatf("v%0d new_pc", i), bus.ctrl_pc_o[32:1], cv[i].npc);
      chk($sformatf("v%0d is_int", i), 32'(bus.ctrl_pc_o[0]), 32'(cv[i].isint));
      chk($sformatf("v%0d exc_we", i), 32'(bus.exc_we), 32'(cv[i].we));
      chk($sformatf("v%0d ertn_o", i), 32'(bus.ertn_o), 32'(cv[i].ertn_o));
      chk($sformatf("v%0d badv_we", i), 32'(bus.exc_badv_we), 32'(cv[i].bwe));
      if (cv[i].we) begin
        chk($sformatf("v%0d ecode", i), 32'(bus.exc_ecode), 32'(cv[i].ecode));
        chk($sformatf("v%0d era", i), bus.exc_era, PC);
      end
      if (cv[i].bwe) chk($sformatf("v%0d badv", i), bus.exc_badv, cv[i].badv);
      idle_in();
      cyc(1);
      chk($sformatf("v%0d flush+2", i), 32'(bus.ctrl_o[0]), 32'd0);
      chk($sformatf("v%0d pulses+2", i), 32'({bus.exc_we, bus.ertn_o, bus.exc_badv_we}), 32'd0);
      chk($sformatf("v%0d new_pc hold", i), bus.ctrl_pc_o[32:1], cv[i].npc);
      cyc(3);
    end
    // exception held through FLUSH/RECOVER: only the first and the post-recovery commit flush
    drive(1'b1, 6'b000010, {28'd0, 7'h09, 7'd0}, 1'b0, 1'b0);
    cyc(1);
    bus.pause_i = 4'b0010;
    #1;
    chk("flush-state pause forced 0", 32'(bus.ctrl_o), 32'h01);
    cyc(1);
    chk("recover pause_ex", 32'(bus.ctrl_o), 32'h3E);
    cyc(1);
    chk("ignored recover1", 32'(bus.ctrl_o[0]), 32'd0);
    cyc(1);
    chk("ignored recover2", 32'(bus.ctrl_o[0]), 32'd0);
    cyc(1);
    chk("retaken after recover", 32'(bus.ctrl_o[0]), 32'd1);
    idle_in();
    cyc(4);
    // no commit while invalid or MEM-paused; pending interrupt waits
    drive(1'b0, 6'b000010, {28'd0, 7'h09, 7'd0}, 1'b1, 1'b0);
    cyc(2);
    chk("no commit invalid", 32'(bus.ctrl_o[0]), 32'd0);
    drive(1'b1, 6'd0, 42'd0, 1'b1, 1'b0);
    bus.pause_i = 4'b0001;
    cyc(1);
    chk("no commit pause_mem", 32'(bus.ctrl_o[0]), 32'd0);
    bus.pause_i = 4'd0;
    cyc(1);
    chk("irq after pause flush", 32'(bus.ctrl_o[0]), 32'd1);
    chk("irq after pause is_int", 32'(bus.ctrl_pc_o[0]), 32'd1);
    idle_in();
    cyc(4);
    // reset while in FLUSH
    drive(1'b1, 6'b100000, {7'h3F, 35'd0}, 1'b0, 1'b0);
    cyc(1);
    chk("pre-reset flush", 32'(bus.ctrl_o[0]), 32'd1);
    idle_in();
    rst = 1'b0;
    cyc(1);
    chk("mid-flush rst flush", 32'(bus.ctrl_o[0]), 32'd0);
    chk("mid-flush rst pc", 32'(bus.ctrl_pc_o != 33'd0), 32'd0);
    chk("mid-flush rst exc_we", 32'(bus.exc_we), 32'd0);
    chk("mid-flush rst ecode", 32'(bus.exc_ecode), 32'd0);
    rst = 1'b1;
    drive(1'b1, 6'd0, 42'd0, 1'b0, 1'b1);
    cyc(1);
    chk("idle after rst ertn", 32'(bus.ertn_o), 32'd1);
    chk("idle after rst new_pc", bus.ctrl_pc_o[32:1], ERA);
    idle_in();
    cyc(4);
    bus.pause_i = 4'b0001;
`ifdef PAUSE_WATCHDOG_EN
    cyc(WDOG - 1);
    chk("wdog before limit", 32'(bus.wdog_timeout), 32'd0);
    cyc(1);
    chk("wdog at limit", 32'(bus.wdog_timeout), 32'd1);
    bus.pause_i = 4'd0;
    cyc(3);
    chk("wdog sticky", 32'(bus.wdog_timeout), 32'd1);
`else
    cyc(50);
    chk("wdog tied 0", 32'(bus.wdog_timeout), 32'd0);
    bus.pause_i = 4'd0;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
